amo_shim_mh: RTL

Multi-hart, width-parametrised atomic-memory shim placed directly in front of a single-port SRAM bank with exclusive access to it. It passes ordinary loads and stores through and executes RISC-V A-extension AMOs as a read-modify-write over two cycles. It keeps one LR/SC reservation per hart, and any write to a reserved row invalidates that reservation, so several cores can share one bank.

---
 rtl/amo_shim_mh.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/amo_shim_mh.sv
// Atomic-memory shim in front of a single-port SRAM bank: forwards plain loads and stores,
// runs RISC-V AMOs as a two-cycle read-modify-write, and keeps one LR/SC reservation per hart.
module amo_shim_mh #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned NumHarts     = 4,
    parameter int unsigned HartIdWidth  = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_req_i,
    output logic                      in_gnt_o,
    input  logic [HartIdWidth-1:0]    in_hart_i,
    input  logic [AddrMemWidth-1:0]   in_add_i,
    input  logic [3:0]                in_amo_i,
    input  logic                      in_wen_i,
    input  logic [DataWidth-1:0]      in_wdata_i,
    input  logic [DataWidth/8-1:0]    in_be_i,
    output logic                      in_rvalid_o,
    output logic [DataWidth-1:0]      in_rdata_o,
    output logic                      out_req_o,
    output logic                      out_wen_o,
    output logic [AddrMemWidth-1:0]   out_add_o,
    output logic [DataWidth-1:0]      out_wdata_o,
    output logic [DataWidth/8-1:0]    out_be_o,
    input  logic [DataWidth-1:0]      out_rdata_i
);
    localparam int unsigned Lanes        = DataWidth / 32;
    localparam int unsigned LaneIdxWidth = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned BeWidth      = DataWidth / 8;

    localparam logic [3:0] OpSwap = 4'h1, OpAdd = 4'h2, OpAnd = 4'h3, OpOr = 4'h4,
                           OpXor = 4'h5, OpMax = 4'h6, OpMaxu = 4'h7, OpMin = 4'h8,
                           OpMinu = 4'h9, OpCas = 4'hA, OpLr = 4'hB, OpSc = 4'hC;

    typedef enum logic {Idle, DoAmo} state_e;

    state_e                    state_q;
    logic                      rvalid_q;
    logic [3:0]                amoOp_q;
    logic [HartIdWidth-1:0]    hart_q;
    logic [AddrMemWidth-1:0]   addr_q;
    logic [LaneIdxWidth-1:0]   lane_q;
    logic [31:0]               opB_q;
    logic [31:0]               opSwap_q;
    logic [NumHarts-1:0]       resValid_q;
    logic [AddrMemWidth-1:0]   resAddr_q [NumHarts];

    logic                      isRmw, isLr, isStore;
    logic [HartIdWidth-1:0]    hartIn;
    logic [LaneIdxWidth-1:0]   laneIn;
    logic [LaneIdxWidth-1:0]   swapLaneIn;
    logic [31:0]               opA, result, respLane;
    logic                      scOk;

    always_comb begin
        isRmw   = ((in_amo_i >= OpSwap) && (in_amo_i <= OpCas)) || (in_amo_i == OpSc);
        isLr    = (in_amo_i == OpLr);
        isStore = in_wen_i && !isRmw && !isLr;
        hartIn  = (32'(in_hart_i) < NumHarts) ? in_hart_i : '0;
        // Descending scan so the lowest lane with its first byte enabled wins.
        laneIn  = '0;
        for (int i = int'(Lanes) - 1; i >= 0; i--) begin
            if (in_be_i[4*i]) laneIn = LaneIdxWidth'(i);
        end
        swapLaneIn = (Lanes > 1) ? (laneIn ^ LaneIdxWidth'(1)) : laneIn;
    end

    always_comb begin
        opA      = 32'(out_rdata_i >> (32 * lane_q));
        scOk     = resValid_q[hart_q] && (resAddr_q[hart_q] == addr_q);
        result   = opA;
        respLane = opA;
        case (amoOp_q)
            OpSwap: result = opB_q;
            OpAdd:  result = opA + opB_q;
            OpAnd:  result = opA & opB_q;
            OpOr:   result = opA | opB_q;
            OpXor:  result = opA ^ opB_q;
            OpMax:  result = ($signed({opA[31], opA}) > $signed({opB_q[31], opB_q})) ? opA : opB_q;
            OpMaxu: result = ({1'b0, opA} > {1'b0, opB_q}) ? opA : opB_q;
            OpMin:  result = ($signed({opA[31], opA}) < $signed({opB_q[31], opB_q})) ? opA : opB_q;
            OpMinu: result = ({1'b0, opA} < {1'b0, opB_q}) ? opA : opB_q;
            OpCas:  result = (opA == opB_q) ? opSwap_q : opA;
            OpSc: begin
                result   = scOk ? opB_q : opA;
                respLane = {31'b0, ~scOk};
            end
            default: ;
        endcase
    end

    always_comb begin
        in_gnt_o    = 1'b0;
        out_req_o   = 1'b0;
        out_wen_o   = 1'b0;
        out_add_o   = in_add_i;
        out_wdata_o = in_wdata_i;
        out_be_o    = in_be_i;
        in_rdata_o  = out_rdata_i;
        if (state_q == Idle) begin
            in_gnt_o  = in_req_i && !rst_i;
            out_req_o = in_req_i && !rst_i;
            out_wen_o = isStore;
        end else begin
            out_req_o   = !rst_i;
            out_wen_o   = 1'b1;
            out_add_o   = addr_q;
            out_wdata_o = DataWidth'(result) << (32 * lane_q);
            out_be_o    = BeWidth'(4'hF) << (4 * lane_q);
            in_rdata_o  = DataWidth'(respLane) << (32 * lane_q);
        end
    end

    assign in_rvalid_o = rvalid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= Idle;
            rvalid_q   <= 1'b0;
            amoOp_q    <= '0;
            hart_q     <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
            opB_q      <= '0;
            opSwap_q   <= '0;
            resValid_q <= '0;
            for (int h = 0; h < int'(NumHarts); h++) resAddr_q[h] <= '0;
        end else begin
            rvalid_q <= in_gnt_o;
            case (state_q)
                Idle: begin
                    if (in_req_i) begin
                        if (isRmw) begin
                            state_q  <= DoAmo;
                            amoOp_q  <= in_amo_i;
                            hart_q   <= hartIn;
                            addr_q   <= in_add_i;
                            lane_q   <= laneIn;
                            opB_q    <= 32'(in_wdata_i >> (32 * laneIn));
                            opSwap_q <= 32'(in_wdata_i >> (32 * swapLaneIn));
                        end else if (isLr) begin
                            resValid_q[hartIn] <= 1'b1;
                            resAddr_q[hartIn]  <= in_add_i;
                        end else if (isStore) begin
                            for (int h = 0; h < int'(NumHarts); h++) begin
                                if (resAddr_q[h] == in_add_i) resValid_q[h] <= 1'b0;
                            end
                        end
                    end
                end
                DoAmo: begin
                    state_q <= Idle;
                    // A failed SC only writes back the old value, so it leaves other harts alone.
                    if (amoOp_q != OpSc || scOk) begin
                        for (int h = 0; h < int'(NumHarts); h++) begin
                            if (resAddr_q[h] == addr_q) resValid_q[h] <= 1'b0;
                        end
                    end
                    if (amoOp_q == OpSc) resValid_q[hart_q] <= 1'b0;
                end
                default: state_q <= Idle;
            endcase
        end
    end
endmodule
